// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader slice.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        HOLD = 3'd2,
        RUN  = 3'd3,
        ERR  = 3'd4
    } boot_state_t;

    localparam logic [31:0] PC_INITIAL = 32'hbfc00000;
    localparam int          WORD_BYTES = 4;

endpackage

// File: rtl/boot_loader_if.sv
// Program-word stream into the boot loader (valid/ready, data or address-jump records).
interface boot_loader_if #(parameter int DATA_W = 32);

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_is_addr;
    logic              s_last;

    modport master (output s_valid, s_data, s_is_addr, s_last, input s_ready);
    modport slave  (input s_valid, s_data, s_is_addr, s_last, output s_ready);

endinterface

// File: rtl/boot_hold_timer.sv
// Post-load hold timer: loaded on HOLD entry, pulses expire on the last HOLD cycle.
module boot_hold_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);

    logic [CW-1:0] cnt;

    // Loaded with HOLD_CYCLES-1 so that expire lands in the HOLD_CYCLES-th HOLD cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (load)
            cnt <= CW'(HOLD_CYCLES - 1);
        else if (en && cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign expire = en && (cnt == '0);

endmodule

// File: rtl/boot_loader.sv
// Fills instruction RAM from a record stream, then releases the CPU after a hold.
// Optional BOOT_LOADER_CHECKSUM_EN adds a data-word checksum check before release.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int              ADDR_W      = 32,
    parameter int              DATA_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(PC_INITIAL),
    parameter int              MAX_WORDS   = 256,
    parameter int              HOLD_CYCLES = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    boot_loader_if.slave                     s,
    output logic                             inst_ram_write_enable,
    output logic [ADDR_W-1:0]                inst_ram_write_address,
    output logic [DATA_W-1:0]                inst_ram_write_data,
    output logic                             debug,
    output logic                             cpu_reset,
    output logic                             done,
    output logic                             error,
    output logic [$clog2(MAX_WORDS+1)-1:0]   word_count
`ifdef BOOT_LOADER_CHECKSUM_EN
    ,
    input  logic [DATA_W-1:0]                expected_sum,
    output logic [DATA_W-1:0]                checksum
`endif
);

    localparam int CW = $clog2(MAX_WORDS + 1);

    localparam logic [2:0] S_IDLE = IDLE;
    localparam logic [2:0] S_LOAD = LOAD;
    localparam logic [2:0] S_HOLD = HOLD;
    localparam logic [2:0] S_RUN  = RUN;
    localparam logic [2:0] S_ERR  = ERR;

    logic [2:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic              rdy;
    logic              go, hs, ovf, wr, to_hold, expire, sum_ok;

    // rdy is only ever set in LOAD, so a handshake implies LOAD.
    assign go      = start && (state == S_IDLE || state == S_RUN || state == S_ERR);
    assign hs      = s.s_valid && rdy;
    assign ovf     = hs && !s.s_is_addr && (word_count == CW'(MAX_WORDS));
    assign wr      = hs && !s.s_is_addr && !ovf;
    assign to_hold = hs && s.s_last && !ovf;

    assign s.s_ready = rdy;
    assign debug     = (state != S_RUN);
    assign cpu_reset = (state != S_RUN);
    assign done      = (state == S_RUN);
    assign error     = (state == S_ERR);

    boot_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
        .clk    (clk),
        .reset  (reset),
        .load   (to_hold),
        .en     (state == S_HOLD),
        .expire (expire)
    );

`ifdef BOOT_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            checksum <= '0;
        else if (go)
            checksum <= '0;
        else if (wr)
            checksum <= checksum + s.s_data;
    end

    assign sum_ok = (checksum == expected_sum);
`else
    assign sum_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                  <= S_IDLE;
            rdy                    <= 1'b0;
            ptr                    <= BASE_ADDR;
            word_count             <= '0;
            inst_ram_write_enable  <= 1'b0;
            inst_ram_write_address <= BASE_ADDR;
            inst_ram_write_data    <= '0;
        end else begin
            inst_ram_write_enable <= 1'b0;
            case (state)
                S_IDLE, S_RUN, S_ERR: begin
                    if (go) begin
                        state      <= S_LOAD;
                        rdy        <= 1'b1;
                        ptr        <= BASE_ADDR;
                        word_count <= '0;
                    end
                end
                S_LOAD: begin
                    if (ovf) begin
                        state <= S_ERR;
                        rdy   <= 1'b0;
                    end else if (hs) begin
                        // Jump offsets are word-aligned and relative to BASE_ADDR; wrap is silent.
                        if (s.s_is_addr) begin
                            ptr <= BASE_ADDR + {s.s_data[ADDR_W-1:2], 2'b00};
                        end else begin
                            inst_ram_write_enable  <= 1'b1;
                            inst_ram_write_address <= ptr;
                            inst_ram_write_data    <= s.s_data;
                            ptr                    <= ptr + ADDR_W'(WORD_BYTES);
                            word_count             <= word_count + CW'(1);
                        end
                        if (s.s_last) begin
                            state <= S_HOLD;
                            rdy   <= 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    if (expire)
                        state <= sum_ok ? S_RUN : S_ERR;
                end
                default: begin
                    state <= S_IDLE;
                    rdy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: default instance plus a MAX_WORDS=4 instance for overflow.
`timescale 1ns/1ps
module tb_boot_loader;

    localparam int          HOLD = 4;
    localparam logic [31:0] BASE = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        v = 1'b0, ia = 1'b0, last = 1'b0, sel = 1'b0;
    logic [31:0] d = '0;
    logic [31:0] exp_sum = '0;

    always #5 clk = ~clk;

    boot_loader_if #(.DATA_W(32)) sa ();
    boot_loader_if #(.DATA_W(32)) sb ();

    assign sa.s_valid = v & ~sel;
    assign sa.s_data = d;
    assign sa.s_is_addr = ia;
    assign sa.s_last = last;
    assign sb.s_valid = v & sel;
    assign sb.s_data = d;
    assign sb.s_is_addr = ia;
    assign sb.s_last = last;

    logic        a_we, a_dbg, a_cr, a_done, a_err, b_we, b_dbg, b_cr, b_done, b_err;
    logic [31:0] a_addr, a_data, b_addr, b_data, a_sum, b_sum;
    logic [8:0]  a_wc;
    logic [2:0]  b_wc;

    boot_loader #(.HOLD_CYCLES(HOLD)) dut_a (
        .clk(clk), .reset(reset), .start(start), .s(sa),
        .inst_ram_write_enable(a_we), .inst_ram_write_address(a_addr), .inst_ram_write_data(a_data),
        .debug(a_dbg), .cpu_reset(a_cr), .done(a_done), .error(a_err), .word_count(a_wc)
`ifdef BOOT_LOADER_CHECKSUM_EN
        , .expected_sum(exp_sum), .checksum(a_sum)
`endif
    );

    boot_loader #(.MAX_WORDS(4), .HOLD_CYCLES(HOLD)) dut_b (
        .clk(clk), .reset(reset), .start(start), .s(sb),
        .inst_ram_write_enable(b_we), .inst_ram_write_address(b_addr), .inst_ram_write_data(b_data),
        .debug(b_dbg), .cpu_reset(b_cr), .done(b_done), .error(b_err), .word_count(b_wc)
`ifdef BOOT_LOADER_CHECKSUM_EN
        , .expected_sum(exp_sum), .checksum(b_sum)
`endif
    );

    wire        m_we   = sel ? b_we   : a_we;
    wire [31:0] m_addr = sel ? b_addr : a_addr;
    wire [31:0] m_data = sel ? b_data : a_data;
    wire        m_rdy  = sel ? sb.s_ready : sa.s_ready;
    wire        m_dbg  = sel ? b_dbg  : a_dbg;
    wire        m_cr   = sel ? b_cr   : a_cr;
    wire        m_done = sel ? b_done : a_done;
    wire        m_err  = sel ? b_err  : a_err;

    int          pass_cnt = 0, total_cnt = 0;
    int          cyc = 0, first_wr = -1, last_wr = -1;
    logic [63:0] sbq[$];
    logic [63:0] exp_w;
    logic [31:0] mptr = BASE;
    int          mcnt = 0, mmax = 256;

    always @(posedge clk) cyc++;

    // Every write strobe must match the oldest expected {address,data}.
    always @(negedge clk) begin
        if (m_we) begin
            total_cnt++;
            if (sbq.size() == 0) begin
                $display("FAIL unexpected_write: got addr %h data %h, expected no write", m_addr, m_data);
            end else begin
                exp_w = sbq.pop_front();
                if ({m_addr, m_data} !== exp_w)
                    $display("FAIL write: got %h/%h want %h/%h", m_addr, m_data, exp_w[63:32], exp_w[31:0]);
                else
                    pass_cnt++;
            end
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        v = 1'b0; ia = 1'b0; last = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
        mptr = BASE; mcnt = 0;
    endtask

    task automatic send(input logic a, input logic [31:0] w, input logic l);
        bit got = 1'b0;
        v = 1'b1; ia = a; d = w; last = l;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (m_rdy) begin
                got = 1'b1;
                if (a) mptr = BASE + {w[31:2], 2'b00};
                else if (mcnt < mmax) begin
                    sbq.push_back({mptr, w}); mptr += 4; mcnt++;
                end
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            total_cnt++;
            $display("FAIL send_timeout: s_ready %b, required 1 within 20 cycles", m_rdy);
        end
    endtask

    task automatic wait_end(output int t);
        t = -1;
        for (int i = 0; i < 30 && t < 0; i++) begin
            @(negedge clk);
            if (m_done || m_err) t = cyc;
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (m_rdy !== 1'b0) $display("FAIL rst_ready: got %b want 0", m_rdy); else pass_cnt++;
        total_cnt++; if (m_we !== 1'b0) $display("FAIL rst_we: got %b want 0", m_we); else pass_cnt++;
        total_cnt++; if (m_addr !== BASE) $display("FAIL rst_addr: got %h want %h", m_addr, BASE); else pass_cnt++;
        total_cnt++; if (m_data !== 32'h0) $display("FAIL rst_data: got %h want 0", m_data); else pass_cnt++;
        total_cnt++; if ({m_dbg, m_cr} !== 2'b11) $display("FAIL rst_cpu: got %b want 11", {m_dbg, m_cr}); else pass_cnt++;
        total_cnt++; if ({m_done, m_err} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {m_done, m_err}); else pass_cnt++;
        total_cnt++; if (a_wc !== 9'd0) $display("FAIL rst_wc: got %0d want 0", a_wc); else pass_cnt++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int t;
        sel = 1'b0; mmax = 256;
        do_start();
        total_cnt++; if (m_rdy !== 1'b1) $display("FAIL start_ready: got %b want 1", m_rdy); else pass_cnt++;
        first_wr = -1;
        send(1'b0, 32'h200F0AF4, 1'b0);
        send(1'b0, 32'h20180008, 1'b0);
        send(1'b0, 32'h01F87820, 1'b1);
        idle();
        t = -1;
        for (int i = 0; i < 30 && t < 0; i++) begin
            @(negedge clk);
            if (!m_cr) t = cyc;
        end
        total_cnt++; if (last_wr - first_wr !== 2) $display("FAIL b2b_span: got %0d want 2", last_wr - first_wr); else pass_cnt++;
        total_cnt++; if (t - last_wr !== HOLD) $display("FAIL release_delay: got %0d want %0d", t - last_wr, HOLD); else pass_cnt++;
        total_cnt++; if (a_wc !== 9'd3) $display("FAIL basic_wc: got %0d want 3", a_wc); else pass_cnt++;
        total_cnt++; if ({m_done, m_dbg, m_rdy} !== 3'b100) $display("FAIL basic_run: got %b want 100", {m_done, m_dbg, m_rdy}); else pass_cnt++;
    endtask

    task automatic test_jump();
        int t;
        do_start();
        for (int k = 0; k < 4; k++) send(1'b0, 32'hA0000000 + k, 1'b0);
        send(1'b1, 32'h0000001C, 1'b0);
        send(1'b0, 32'h21290001, 1'b0);
        send(1'b0, 32'h21290001, 1'b1);
        idle();
        wait_end(t);
        total_cnt++; if (m_done !== 1'b1) $display("FAIL jump_done: got %b want 1", m_done); else pass_cnt++;
        total_cnt++; if (a_wc !== 9'd6) $display("FAIL jump_wc: got %0d want 6", a_wc); else pass_cnt++;
    endtask

    task automatic test_overflow();
        int t;
        sel = 1'b1; mmax = 4;
        do_start();
        for (int k = 0; k < 5; k++) send(1'b0, 32'h00001000 + k, k == 4);
        idle();
        @(negedge clk);
        total_cnt++; if (m_err !== 1'b1) $display("FAIL ovf_error: got %b want 1", m_err); else pass_cnt++;
        total_cnt++; if (m_rdy !== 1'b0) $display("FAIL ovf_ready: got %b want 0", m_rdy); else pass_cnt++;
        total_cnt++; if ({m_dbg, m_cr, m_done} !== 3'b110) $display("FAIL ovf_cpu: got %b want 110", {m_dbg, m_cr, m_done}); else pass_cnt++;
        total_cnt++; if (b_wc !== 3'd4) $display("FAIL ovf_wc: got %0d want 4", b_wc); else pass_cnt++;
        total_cnt++; if (sbq.size() !== 0) $display("FAIL ovf_pending: got %0d want 0", sbq.size()); else pass_cnt++;
        do_start();
        total_cnt++; if ({m_err, m_rdy} !== 2'b01) $display("FAIL ovf_restart: got %b want 01", {m_err, m_rdy}); else pass_cnt++;
        send(1'b0, 32'hCAFE0001, 1'b1);
        idle();
        wait_end(t);
        total_cnt++; if (m_done !== 1'b1) $display("FAIL ovf_reload_done: got %b want 1", m_done); else pass_cnt++;
        sel = 1'b0; mmax = 256;
    endtask

    task automatic test_toggle();
        int t;
        do_start();
        for (int k = 0; k < 6; k++) begin
            send(1'b0, 32'h55000000 + k, k == 5);
            idle();
            if (k == 2) begin
                start = 1'b1; tick(); start = 1'b0;
                @(negedge clk);
                total_cnt++; if ({m_rdy, m_dbg} !== 2'b11) $display("FAIL start_ignored: got %b want 11", {m_rdy, m_dbg}); else pass_cnt++;
                tick();
            end else begin
                tick();
            end
        end
        wait_end(t);
        total_cnt++; if (m_done !== 1'b1) $display("FAIL toggle_done: got %b want 1", m_done); else pass_cnt++;
        total_cnt++; if (a_wc !== 9'd6) $display("FAIL toggle_wc: got %0d want 6", a_wc); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_start();
        send(1'b0, 32'h77000000, 1'b0);
        send(1'b0, 32'h77000001, 1'b0);
        v = 1'b1; d = 32'h77000002;
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        total_cnt++; if (m_we !== 1'b0) $display("FAIL abort_we: got %b want 0", m_we); else pass_cnt++;
        total_cnt++; if ({m_dbg, m_cr, m_rdy} !== 3'b110) $display("FAIL abort_cpu: got %b want 110", {m_dbg, m_cr, m_rdy}); else pass_cnt++;
        total_cnt++; if (a_wc !== 9'd0) $display("FAIL abort_wc: got %0d want 0", a_wc); else pass_cnt++;
        total_cnt++; if (m_addr !== BASE) $display("FAIL abort_addr: got %h want %h", m_addr, BASE); else pass_cnt++;
        idle();
        @(negedge clk);
        #1 reset = 1'b1;
        tick();
        @(negedge clk);
        total_cnt++; if ({m_we, m_rdy, m_done} !== 3'b000) $display("FAIL abort_idle: got %b want 000", {m_we, m_rdy, m_done}); else pass_cnt++;
    endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int t;
        for (int r = 0; r < 2; r++) begin
            exp_sum = (r == 0) ? 32'd6 : 32'd7;
            do_start();
            send(1'b0, 32'd1, 1'b0);
            send(1'b0, 32'd2, 1'b0);
            send(1'b0, 32'd3, 1'b1);
            idle();
            wait_end(t);
            total_cnt++; if (a_sum !== 32'd6) $display("FAIL checksum_val: got %0d want 6", a_sum); else pass_cnt++;
            total_cnt++;
            if ({m_done, m_err} !== ((r == 0) ? 2'b10 : 2'b01))
                $display("FAIL checksum_result: got %b want %b", {m_done, m_err}, (r == 0) ? 2'b10 : 2'b01);
            else pass_cnt++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_jump();
        test_overflow();
        test_toggle();
        test_reset_mid();
`ifdef BOOT_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (2) @(negedge clk);
        total_cnt++; if (sbq.size() !== 0) $display("FAIL pending_writes: got %0d want 0", sbq.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
